// File: rtl/out_port_fifo_pkg.sv
// ---------------------------------------------------------------------------
// out_port_fifo_pkg
// Shared configuration for the processor output-port buffer.
//
// Project-wide defines (normally supplied by the shared defines file; the
// fallbacks below keep a standalone build complete):
//   `inPortWidth     - width of one processor port word
//   `OUT_FIFO_DEPTH  - default number of buffered words (power of two, >= 2)
//   OUT_FIFO_OVERFLOW_EN - when defined, out_port_fifo gains the sticky
//                          overflow flag and its clr_overflow input
// ---------------------------------------------------------------------------
`ifndef inPortWidth
`define inPortWidth 16
`endif

`ifndef OUT_FIFO_DEPTH
`define OUT_FIFO_DEPTH 8
`endif

package out_port_fifo_pkg;

  // Default word width of the output port.
  localparam int OUT_FIFO_DATA_W = `inPortWidth;

  // Default number of buffered words.
  localparam int OUT_FIFO_DEPTH_DEF = `OUT_FIFO_DEPTH;

endpackage

// File: rtl/out_fifo_mem.sv
// ---------------------------------------------------------------------------
// out_fifo_mem
// Storage array for out_port_fifo: DEPTH x DATA_WIDTH registers with one
// synchronous write port and one asynchronous read port. The asynchronous
// read gives the enclosing FIFO its first-word-fall-through behaviour.
// The array is intentionally not reset.
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  word stored at raddr (combinational)
// ---------------------------------------------------------------------------
module out_fifo_mem
  import out_port_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = OUT_FIFO_DATA_W,
  parameter int DEPTH      = OUT_FIFO_DEPTH_DEF,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// ---------------------------------------------------------------------------
// out_port_fifo
// Buffers every word the processor writes to its output port and hands the
// words to an external device over a valid/ready handshake, so that port
// writes are not lost while the device stalls. First-word-fall-through:
// out_data always shows the oldest stored word.
//
// Optional feature macro: OUT_FIFO_OVERFLOW_EN adds a sticky overflow flag
// (set by a dropped write) and a clr_overflow input that clears it.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous reset, active low
//   wr_en         in   write strobe (processor outSignalEn)
//   wr_data       in   write word (processor outPortData)
//   out_valid     out  head word available (== !empty)
//   out_data      out  head word
//   out_ready     in   device takes the head word this cycle
//   full          out  count == DEPTH
//   empty         out  count == 0
//   count         out  number of stored words
//   overflow      out  sticky drop flag        (OUT_FIFO_OVERFLOW_EN only)
//   clr_overflow  in   clears overflow         (OUT_FIFO_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module out_port_fifo
  import out_port_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = OUT_FIFO_DATA_W,
  parameter  int DEPTH      = OUT_FIFO_DEPTH_DEF,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count
`ifdef OUT_FIFO_OVERFLOW_EN
  ,
  output logic                  overflow,
  input  logic                  clr_overflow
`endif
);

  localparam int               CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_readFire;
  logic w_writeAccept;

  // Full/empty come from the occupancy count, never from pointer equality.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // A read while full frees the slot being written in the same cycle, so
  // out_ready feeds write acceptance combinationally; this is the only
  // input-to-decision path through the block.
  assign w_readFire    = !w_empty && out_ready;
  assign w_writeAccept = wr_en && (!w_full || w_readFire);

  // Pointers are exactly ADDR_W bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_writeAccept) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_readFire) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      if (w_writeAccept && !w_readFire) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_writeAccept && w_readFire) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  out_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_writeAccept),
    .waddr (r_wrPtr),
    .wdata (wr_data),
    .raddr (r_rdPtr),
    .rdata (out_data)
  );

`ifdef OUT_FIFO_OVERFLOW_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop = wr_en && !w_writeAccept;

  // A drop wins over a clear in the same cycle so no loss goes unreported.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`endif

  assign out_valid = !w_empty;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;

endmodule

// File: tb/tb_out_port_fifo.sv
// ---------------------------------------------------------------------------
// tb_out_port_fifo
// Self-checking bench for out_port_fifo (DEPTH 8, 16-bit words). A queue
// model of the FIFO rules supplies expected values for randomized traffic;
// directed scenarios check the documented corner cases against constants.
// ---------------------------------------------------------------------------
module tb_out_port_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          full;
  logic          empty;
  logic [3:0]    count;
`ifdef OUT_FIFO_OVERFLOW_EN
  logic          overflow;
  logic          clr_overflow;
`endif

  int checks;
  int errors;

  // Reference model: queue of stored words plus sticky drop flag.
  logic [DW-1:0] mQ[$];
  bit            mOvf;

  out_port_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .full         (full),
    .empty        (empty),
    .count        (count)
`ifdef OUT_FIFO_OVERFLOW_EN
    ,
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; the model advances by the FIFO rules.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    bit fire;
    bit acc;
    wr_en     = w;
    wr_data   = d;
    out_ready = r;
`ifdef OUT_FIFO_OVERFLOW_EN
    clr_overflow = c;
`endif
    fire = (mQ.size() > 0) && r;
    acc  = w && ((mQ.size() < DEPTH) || fire);
    @(posedge clk);
    if (fire) void'(mQ.pop_front());
    if (acc) mQ.push_back(d);
    if (w && !acc) mOvf = 1'b1;
    else if (c) mOvf = 1'b0;
    #1;
    wr_en     = 1'b0;
    out_ready = 1'b0;
`ifdef OUT_FIFO_OVERFLOW_EN
    clr_overflow = 1'b0;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got count=%0d empty=%b valid=%b full=%b, expected 0/1/0/0", count, empty, out_valid, full);
    end
`ifdef OUT_FIFO_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    mQ.delete();
    mOvf = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_ready: got count=%0d empty=%b valid=%b, expected 0/1/0", count, empty, out_valid);
    end
    cycle(1'b1, 16'h00AA, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h00AA || count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL first_write: got valid=%b data=%h count=%0d, expected 1/00aa/1", out_valid, out_data, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_drain: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_in_order();
    for (int i = 1; i <= 3; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("[TB] FAIL in_order_count: got %0d expected 3", count);
    end
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
        errors++;
        $display("[TB] FAIL in_order_data: got valid=%b data=%h expected 1/%h", out_valid, out_data, DW'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL in_order_empty: got empty=%b valid=%b expected 1/0", empty, out_valid);
    end
  endtask

  task automatic test_fill_drop();
    for (int i = 0; i < 9; i++) cycle(1'b1, 16'h1000 + DW'(i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL fill_full: got full=%b count=%0d expected 1/8", full, count);
    end
`ifdef OUT_FIFO_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_overflow_set: got %b expected 1", overflow);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_data !== 16'h1000 + DW'(i)) begin
        errors++;
        $display("[TB] FAIL fill_drain: got %h expected %h", out_data, 16'h1000 + DW'(i));
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_drop_lost: got empty=%b full=%b expected 1/0", empty, full);
    end
`ifdef OUT_FIFO_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got %b expected 0", overflow);
    end
`endif
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] expWord;
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h00A0 + DW'(i), 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || out_data !== 16'h00A0) begin
      errors++;
      $display("[TB] FAIL full_rw_pre: got full=%b head=%h expected 1/00a0", full, out_data);
    end
    cycle(1'b1, 16'h00BB, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd8 || out_data !== 16'h00A1) begin
      errors++;
      $display("[TB] FAIL full_rw_both: got count=%0d head=%h expected 8/00a1", count, out_data);
    end
    for (int i = 0; i < 8; i++) begin
      expWord = (i == 7) ? 16'h00BB : 16'h00A1 + DW'(i);
      checks++;
      if (out_data !== expWord) begin
        errors++;
        $display("[TB] FAIL full_rw_drain: got %h expected %h", out_data, expWord);
      end
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] word;
    for (int i = 0; i < 20; i++) begin
      word = DW'($urandom);
      cycle(1'b1, word, 1'b1, 1'b0);
      checks++;
      if (count !== 4'd1 || out_valid !== 1'b1 || out_data !== word) begin
        errors++;
        $display("[TB] FAIL wrap_stream: got count=%0d valid=%b data=%h expected 1/1/%h", count, out_valid, out_data, word);
      end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_end_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0300 + DW'(i), 1'b0, 1'b0);
    checks++;
    if (count !== 4'd5) begin
      errors++;
      $display("[TB] FAIL async_pre_count: got %0d expected 5", count);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset_now: got valid=%b count=%0d empty=%b expected 0/0/1", out_valid, count, empty);
    end
    @(negedge clk);
    reset = 1'b1;
    mQ.delete();
    mOvf = 1'b0;
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    checks++;
    if (out_data !== 16'h5555 || count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL async_first_write: got data=%h count=%0d expected 5555/1", out_data, count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int wrPct;
    int rdPct;
    for (int i = 0; i < 400; i++) begin
      wrPct = ((i / 50) % 2 == 0) ? 80 : 30;
      rdPct = ((i / 50) % 2 == 0) ? 30 : 80;
      cycle(($urandom_range(99) < wrPct), DW'($urandom), ($urandom_range(99) < rdPct),
            ($urandom_range(99) < 10));
      checks++;
      if (count !== 4'(mQ.size()) || empty !== (mQ.size() == 0) ||
          full !== (mQ.size() == DEPTH) || out_valid !== (mQ.size() != 0)) begin
        errors++;
        $display("[TB] FAIL random_flags: got count=%0d empty=%b full=%b valid=%b expected count=%0d",
                 count, empty, full, out_valid, mQ.size());
      end
      if (mQ.size() != 0) begin
        checks++;
        if (out_data !== mQ[0]) begin
          errors++;
          $display("[TB] FAIL random_data: got %h expected %h", out_data, mQ[0]);
        end
      end
`ifdef OUT_FIFO_OVERFLOW_EN
      checks++;
      if (overflow !== mOvf) begin
        errors++;
        $display("[TB] FAIL random_overflow: got %b expected %b", overflow, mOvf);
      end
`endif
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mOvf      = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    out_ready = 1'b0;
`ifdef OUT_FIFO_OVERFLOW_EN
    clr_overflow = 1'b0;
`endif
    test_reset();
    test_in_order();
    test_fill_drop();
    test_full_rw();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
